// File: rtl/scan_decoder_if.sv
// rtl/scan_decoder_if.sv - enable, select and decoded-output bundle for scan_decoder
interface scan_decoder_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_N = 2 ** SEL_W;

    logic             g1;
    logic             g2a_n;
    logic             g2b_n;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] scan_last;
    logic [OUT_N-1:0] y_n;
    logic [SEL_W-1:0] cur_idx;
    logic             step;

    modport master (
        output g1, g2a_n, g2b_n, mode, sel, scan_last,
        input  y_n, cur_idx, step
    );

    modport slave (
        input  g1, g2a_n, g2b_n, mode, sel, scan_last,
        output y_n, cur_idx, step
    );
endinterface

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered SEL_W-to-2^SEL_W active-low decoder with auto-scan (optional SCAN_BLANK_EN blanking)
module scan_decoder #(
    parameter int SEL_W     = 3,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    scan_decoder_if.slave  bus
);
    localparam int OUT_N = 2 ** SEL_W;
    localparam int PW    = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    if (SCAN_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_param
        $error("scan_decoder: SCAN_DIV must be >= 2 and BLANK_CYC in 0..SCAN_DIV-1");
    end

    logic [OUT_N-1:0] r_y_n;
    logic [SEL_W-1:0] r_cur_idx;
    logic             r_step;
    logic [PW-1:0]    r_presc;
    logic             r_mode_q;

    logic             w_enable;
    logic             w_wrap;
    logic [SEL_W-1:0] w_idx_next;
    logic [PW-1:0]    w_presc_next;
    logic             w_step_next;
    logic [OUT_N-1:0] w_y_next;

    assign w_enable = bus.g1 & ~bus.g2a_n & ~bus.g2b_n;
    assign w_wrap   = (r_presc == PRESC_MAX);

    // Next index / prescaler / step / decoded outputs for the coming edge
    always_comb begin
        w_idx_next   = r_cur_idx;
        w_presc_next = r_presc;
        w_step_next  = 1'b0;
        if (!bus.mode) begin
            // direct decode; prescaler parked so a later scan entry starts clean
            w_idx_next   = bus.sel;
            w_presc_next = '0;
        end else if (!r_mode_q) begin
            // first scan cycle: restart the slot sequence from index 0
            w_idx_next   = '0;
            w_presc_next = '0;
        end else if (w_enable) begin
            if (w_wrap) begin
                w_presc_next = '0;
                w_step_next  = 1'b1;
                // >= also catches a scan_last lowered below the current index
                w_idx_next   = (r_cur_idx >= bus.scan_last) ? '0 : r_cur_idx + 1'b1;
            end else begin
                w_presc_next = r_presc + 1'b1;
            end
        end
        // disabled in scan mode: everything frozen, resume later from here

        w_y_next = w_enable ? ~(OUT_N'(1) << w_idx_next) : '1;
`ifdef SCAN_BLANK_EN
        // dead time at the start of each slot to stop ghosting between digits
        if (bus.mode && (int'(w_presc_next) < BLANK_CYC)) begin
            w_y_next = '1;
        end
`endif
    end

    // Output, index and scan state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_n     <= '1;
            r_cur_idx <= '0;
            r_step    <= 1'b0;
            r_presc   <= '0;
            r_mode_q  <= 1'b0;
        end else begin
            r_y_n     <= w_y_next;
            r_cur_idx <= w_idx_next;
            r_step    <= w_step_next;
            r_presc   <= w_presc_next;
            r_mode_q  <= bus.mode;
        end
    end

    assign bus.y_n     = r_y_n;
    assign bus.cur_idx = r_cur_idx;
    assign bus.step    = r_step;
endmodule
